// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants for the seven-segment scan logic
package seg_disp_pkg;
  localparam int NUM_DIGIT_DEF = 6;
  localparam int CNT_W = 20;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [31:0] ENB_ALL_OFF = '1;
endpackage

// File: rtl/seg_scan_sched_scan_timer.sv
// scan_timer: slot counter with clear; tc flags the last cycle of the loaded count
module scan_timer
  import seg_disp_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] tc_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == tc_val;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_scan_sched.sv
// seg_scan_sched: digit scan FSM with dwell/blank slots, digit and blink masks, frame pulse
module seg_scan_sched
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGIT    = NUM_DIGIT_DEF,
  parameter int DWELL_CYC    = 5000,
  parameter int BLANK_CYC    = 50,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [7*NUM_DIGIT-1:0] i_digit_seg,
  input  logic [NUM_DIGIT-1:0]   i_dp,
  input  logic [NUM_DIGIT-1:0]   i_digit_mask,
  input  logic [NUM_DIGIT-1:0]   i_blink_mask,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic [NUM_DIGIT-1:0]   o_seg_enb,
  output logic                   o_frame_done
);
  localparam int IW = NUM_DIGIT > 1 ? $clog2(NUM_DIGIT) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGIT - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYC - 1);
  localparam bit NO_BLANK = BLANK_CYC == 0;
  logic [1:0] state, n_state;
  logic [IW-1:0] idx, n_idx;
  logic [FW-1:0] fc, n_fc;
  logic ph, n_ph, tc, clr, adv, wrap, lit;
  assign clr = !i_en || (state != ST_DWELL && state != ST_BLANK) || tc;
  scan_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .tc_val (state == ST_BLANK ? BLANK_TC : DWELL_TC),
    .tc     (tc)
  );
  // outputs are registered from the next-state view so pins track the state register
  always_comb begin
    adv = tc && (state == ST_BLANK || (state == ST_DWELL && NO_BLANK));
    wrap = adv && idx == LAST_IDX;
    n_state = !i_en ? ST_IDLE :
              state == ST_IDLE ? ST_DWELL :
              state == ST_DWELL ? (tc && !NO_BLANK ? ST_BLANK : ST_DWELL) :
              state == ST_BLANK ? (tc ? ST_DWELL : ST_BLANK) : ST_IDLE;
    n_idx = !i_en || wrap ? '0 : adv ? idx + 1'b1 : idx;
    n_fc = !i_en ? '0 : !wrap ? fc : fc == LAST_FRAME ? '0 : fc + 1'b1;
    n_ph = i_en && (ph ^ (wrap && fc == LAST_FRAME));
    lit = n_state == ST_DWELL && i_digit_mask[n_idx] && !(i_blink_mask[n_idx] && n_ph);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      fc <= '0;
      ph <= 1'b0;
      o_seg <= SEG_BLANK;
      o_seg_dp <= 1'b0;
      o_seg_enb <= NUM_DIGIT'(ENB_ALL_OFF);
      o_frame_done <= 1'b0;
    end else begin
      state <= n_state;
      idx <= n_idx;
      fc <= n_fc;
      ph <= n_ph;
      o_seg <= lit ? i_digit_seg[7*n_idx +: 7] : SEG_BLANK;
      o_seg_dp <= lit && i_dp[n_idx];
      o_seg_enb <= lit ? ~(NUM_DIGIT'(1) << n_idx) : NUM_DIGIT'(ENB_ALL_OFF);
      o_frame_done <= wrap && i_en;
    end
endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: two scan schedulers (with and without blank) against a time-based model
module tb_seg_scan_sched;
  logic clk = 0, rst_n = 1, i_en = 0;
  logic [41:0] seg;
  logic [5:0] dp, dm, bm;
  logic [6:0] a_seg, b_seg;
  logic a_dp, b_dp, a_fd, b_fd;
  logic [5:0] a_enb, b_enb;
  logic [14:0] ea = 15'h003F, eb = 15'h003F;
  bit run;
  int t;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  seg_scan_sched #(.NUM_DIGIT(6), .DWELL_CYC(4), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_digit_seg(seg), .i_dp(dp),
    .i_digit_mask(dm), .i_blink_mask(bm), .o_seg(a_seg), .o_seg_dp(a_dp),
    .o_seg_enb(a_enb), .o_frame_done(a_fd));

  seg_scan_sched #(.NUM_DIGIT(6), .DWELL_CYC(4), .BLANK_CYC(0), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_digit_seg(seg), .i_dp(dp),
    .i_digit_mask(dm), .i_blink_mask(bm), .o_seg(b_seg), .o_seg_dp(b_dp),
    .o_seg_enb(b_enb), .o_frame_done(b_fd));

  // t = cycles since the enabling edge; everything follows from slot/frame arithmetic
  function automatic logic [14:0] model(input bit r, input int tt, input int d, input int b,
                                         input logic [41:0] s, input logic [5:0] p,
                                         input logic [5:0] m, input logic [5:0] k);
    int per, fl, fr, rr, dg, ph;
    bit lit;
    if (!r) return 15'h003F;
    per = d + b;
    fl = 6 * per;
    fr = tt / fl;
    rr = tt % fl;
    dg = rr / per;
    ph = (fr / 2) % 2;
    lit = (rr % per) < d && m[dg] && !(k[dg] && ph == 1);
    return {tt > 0 && rr == 0, lit && p[dg], lit ? s[7*dg +: 7] : 7'b0,
            lit ? ~(6'b000001 << dg) : 6'h3F};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run = 0;
      t = 0;
      ea = 15'h003F;
      eb = 15'h003F;
    end else begin
      if (i_en) begin
        t = run ? t + 1 : 0;
        run = 1;
      end else run = 0;
      ea = model(run, t, 4, 2, seg, dp, dm, bm);
      eb = model(run, t, 4, 0, seg, dp, dm, bm);
    end

  task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_outputs", {a_fd, a_dp, a_seg, a_enb}, ea);
    chk("b_outputs", {b_fd, b_dp, b_seg, b_enb}, eb);
    chk("a_onehot_low", $countones(~a_enb) <= 1, 1);
    chk("b_onehot_low", $countones(~b_enb) <= 1, 1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    dm = '1;
    bm = '0;
    dp = 6'($urandom);
    seg = 42'({$urandom(), $urandom()});
    #1 rst_n = 0;
    repeat (3) tick;
    chk("reset_a", {a_fd, a_dp, a_seg, a_enb}, 15'h003F);
    rst_n = 1;
    tick;
    chk("idle_enb", a_enb, 6'h3F);
    i_en = 1;
    tick;
    chk("t0_a_enb", a_enb, 6'b111110);
    chk("t0_a_seg", a_seg, seg[6:0]);
    chk("t0_b_enb", b_enb, 6'b111110);
    repeat (4) tick;
    chk("t4_a_blank", a_enb, 6'h3F);
    chk("t4_b_digit1", b_enb, 6'b111101);
    repeat (2) tick;
    chk("t6_a_digit1", a_enb, 6'b111101);
    chk("t6_a_seg", a_seg, seg[13:7]);
    repeat (17) tick;
    chk("t23_b_fd", b_fd, 1'b0);
    tick;
    chk("t24_b_fd", b_fd, 1'b1);
    repeat (11) tick;
    chk("t35_a_fd", a_fd, 1'b0);
    tick;
    chk("t36_a_fd", a_fd, 1'b1);
    chk("t36_a_enb", a_enb, 6'b111110);
    dm = 6'b111011;
    repeat (12) tick;
    chk("t48_masked_enb", a_enb, 6'h3F);
    chk("t48_masked_seg", a_seg, 7'b0);
    repeat (24) tick;
    chk("t72_a_fd", a_fd, 1'b1);
    dm = '1;
    bm = 6'b000001;
    tick;
    chk("t73_blink_dark", a_enb, 6'h3F);
    repeat (5) tick;
    chk("t78_digit1_lit", a_enb, 6'b111101);
    repeat (30) tick;
    chk("t108_blink_dark", a_enb, 6'h3F);
    repeat (36) tick;
    chk("t144_blink_lit", a_enb, 6'b111110);
    repeat (600) begin
      seg = 42'({$urandom(), $urandom()});
      dp = 6'($urandom);
      if ($urandom_range(0, 19) == 0) dm = 6'($urandom);
      if ($urandom_range(0, 19) == 0) bm = 6'($urandom);
      i_en = $urandom_range(0, 79) != 0;
      tick;
    end
    dm = '1;
    bm = '0;
    i_en = 0;
    tick;
    i_en = 1;
    tick;
    repeat (19) tick;
    chk("t19_digit3", a_enb, 6'b110111);
    i_en = 0;
    tick;
    chk("drop_enb", a_enb, 6'h3F);
    chk("drop_seg", a_seg, 7'b0);
    bm = '1;
    i_en = 1;
    tick;
    chk("restart_phase0", a_enb, 6'b111110);
    repeat (4) tick;
    #2 rst_n = 0;
    #1;
    chk("async_rst_a", {a_fd, a_dp, a_seg, a_enb}, 15'h003F);
    chk("async_rst_b", {b_fd, b_dp, b_seg, b_enb}, 15'h003F);
    tick;
    rst_n = 1;
    repeat (50) begin
      seg = 42'({$urandom(), $urandom()});
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
